// File: rtl/mem_arr.sv
// mem_arr: banked operand memory feeding the systolic array.
// One independent depth x 8 bank per lane. Each lane has its own read port
// with a registered, zero-padded output and its own write port for host/DMA
// loading. Bank contents are never reset; only the read pipeline is.

module mem_arr #(
  parameter int width_height = 16,
  parameter int depth        = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [width_height-1:0]     rd_en,
  input  logic [8*width_height-1:0]   rd_addr,
  input  logic [width_height-1:0]     wr_en,
  input  logic [8*width_height-1:0]   wr_addr,
  input  logic [8*width_height-1:0]   wr_data,
  output logic [8*width_height-1:0]   rd_data,
  output logic [width_height-1:0]     rd_valid
);

  // Index width needed to address one bank; the 8-bit lane address is
  // range-checked against depth before this slice is used.
  localparam int ADDR_W = (depth > 1) ? $clog2(depth) : 1;

  for (genvar lane = 0; lane < width_height; lane++) begin : g_lane

    logic [7:0]        bank [depth];
    logic [7:0]        lane_rd_addr;
    logic [7:0]        lane_wr_addr;
    logic [7:0]        lane_wr_data;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [7:0]        data_q;
    logic              valid_q;

    assign lane_rd_addr = rd_addr[8*lane +: 8];
    assign lane_wr_addr = wr_addr[8*lane +: 8];
    assign lane_wr_data = wr_data[8*lane +: 8];

    // Addresses at or beyond depth fall outside the bank: reads give zero,
    // writes are dropped.
    assign rd_in_range = ({1'b0, lane_rd_addr} < 9'(depth));
    assign wr_in_range = ({1'b0, lane_wr_addr} < 9'(depth));

    // Bank write port; no reset so contents survive reset, and writes are
    // suppressed while reset is held low.
    always_ff @(posedge clk) begin
      if (reset && wr_en[lane] && wr_in_range) begin
        bank[lane_wr_addr[ADDR_W-1:0]] <= lane_wr_data;
      end
    end

    // Registered read port: old contents on a same-address collision,
    // zero fill when idle or out of range, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= 8'h00;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[lane];
        if (rd_en[lane] && rd_in_range) begin
          data_q <= bank[lane_rd_addr[ADDR_W-1:0]];
        end else begin
          data_q <= 8'h00;
        end
      end
    end

    assign rd_data[8*lane +: 8] = data_q;
    assign rd_valid[lane]       = valid_q;

  end

endmodule

// File: tb/tb_mem_arr.sv
// tb_mem_arr: randomized self-checking bench for mem_arr.
// Two instances share the same stimulus: one full 256-word bank and one
// 64-word bank so the out-of-range behaviour is exercised. A plain array
// model of each bank set predicts every registered output.

module tb_mem_arr;

  localparam int LANES = 16;

  logic          clk;
  logic          reset;
  logic [15:0]   rd_en;
  logic [127:0]  rd_addr;
  logic [15:0]   wr_en;
  logic [127:0]  wr_addr;
  logic [127:0]  wr_data;
  logic [127:0]  d256_rd_data;
  logic [15:0]   d256_rd_valid;
  logic [127:0]  d64_rd_data;
  logic [15:0]   d64_rd_valid;

  logic [7:0]    model256 [LANES][256];
  logic [7:0]    model64  [LANES][64];

  int            vector_count;
  int            miscompare_count;

  mem_arr #(.width_height(16), .depth(256)) dut256 (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (d256_rd_data),
    .rd_valid (d256_rd_valid)
  );

  mem_arr #(.width_height(16), .depth(64)) dut64 (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (d64_rd_data),
    .rd_valid (d64_rd_valid)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %h, expected %h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs from the bank models,
  // then sample just after the rising edge and compare both instances.
  task automatic apply_stimulus(input logic [15:0] ren, input logic [127:0] raddr,
                                input logic [15:0] wen, input logic [127:0] waddr,
                                input logic [127:0] wdata);
    logic [127:0] exp256;
    logic [127:0] exp64;
    logic [15:0]  expv;
    logic [7:0]   a;
    rd_en   = ren;
    rd_addr = raddr;
    wr_en   = wen;
    wr_addr = waddr;
    wr_data = wdata;
    exp256  = '0;
    exp64   = '0;
    expv    = reset ? ren : 16'h0000;
    for (int i = 0; i < LANES; i++) begin
      a = raddr[8*i +: 8];
      if (reset && ren[i]) begin
        exp256[8*i +: 8] = model256[i][a];
        exp64[8*i +: 8]  = (a < 8'd64) ? model64[i][a[5:0]] : 8'h00;
      end
    end
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        a = waddr[8*i +: 8];
        if (wen[i]) begin
          model256[i][a] = wdata[8*i +: 8];
          if (a < 8'd64) model64[i][a[5:0]] = wdata[8*i +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    check_output("rd_data_d256",  d256_rd_data,           exp256);
    check_output("rd_valid_d256", {112'b0, d256_rd_valid}, {112'b0, expv});
    check_output("rd_data_d64",   d64_rd_data,            exp64);
    check_output("rd_valid_d64",  {112'b0, d64_rd_valid},  {112'b0, expv});
  endtask

  // Helper: replicate one byte into every lane slot.
  function automatic logic [127:0] all_lanes(input logic [7:0] b);
    logic [127:0] v;
    for (int i = 0; i < LANES; i++) v[8*i +: 8] = b;
    return v;
  endfunction

  initial begin
    logic [127:0] ra;
    logic [127:0] wa;
    logic [127:0] wd;
    logic [15:0]  en;

    vector_count     = 0;
    miscompare_count = 0;
    reset   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    #12;
    check_output("reset_data_d256",  d256_rd_data,           128'h0);
    check_output("reset_valid_d256", {112'b0, d256_rd_valid}, 128'h0);
    check_output("reset_data_d64",   d64_rd_data,            128'h0);
    check_output("reset_valid_d64",  {112'b0, d64_rd_valid},  128'h0);
    reset = 1'b1;

    // Preload every word: bank i addr j = {i[3:0], j[3:0]}
    for (int j = 0; j < 256; j++) begin
      for (int i = 0; i < LANES; i++) wd[8*i +: 8] = {4'(i), 4'(j)};
      apply_stimulus(16'h0000, '0, 16'hFFFF, all_lanes(8'(j)), wd);
    end

    // Basic write then read
    wa = '0; wd = '0;
    wa[7:0] = 8'd5;   wd[7:0] = 8'hA5;
    wa[127:120] = 8'd255; wd[127:120] = 8'h3C;
    apply_stimulus(16'h0000, '0, 16'h8001, wa, wd);
    apply_stimulus(16'h8001, wa, 16'h0000, '0, '0);
    check_output("basic_lane0",  {120'b0, d256_rd_data[7:0]},     {120'b0, 8'hA5});
    check_output("basic_lane15", {120'b0, d256_rd_data[127:120]}, {120'b0, 8'h3C});
    check_output("basic_valid",  {112'b0, d256_rd_valid},          {112'b0, 16'h8001});

    // Diagonal wavefront: lane i reads address t-i while 0 <= t-i < 16
    for (int t = 0; t < 31; t++) begin
      en = '0; ra = '0;
      for (int i = 0; i < LANES; i++) begin
        if (t >= i && t - i < 16) begin
          en[i] = 1'b1;
          ra[8*i +: 8] = 8'(t - i);
        end
      end
      apply_stimulus(en, ra, 16'h0000, '0, '0);
    end

    // Read/write collision in lane 3 at address 7
    wa = '0; wd = '0;
    wa[31:24] = 8'd7; wd[31:24] = 8'h11;
    apply_stimulus(16'h0000, '0, 16'h0008, wa, wd);
    wd[31:24] = 8'h22;
    apply_stimulus(16'h0008, wa, 16'h0008, wa, wd);
    check_output("collision_old", {120'b0, d256_rd_data[31:24]}, {120'b0, 8'h11});
    apply_stimulus(16'h0008, wa, 16'h0000, '0, '0);
    check_output("collision_new", {120'b0, d256_rd_data[31:24]}, {120'b0, 8'h22});

    // Out-of-range on the 64-word instance: lane 0 addr 100, lane 1 addr 36
    wa = '0; wd = '0;
    wa[7:0] = 8'd100; wd[7:0] = 8'hFF;
    apply_stimulus(16'h0000, '0, 16'h0001, wa, wd);
    ra = '0;
    ra[7:0] = 8'd100; ra[15:8] = 8'd36;
    apply_stimulus(16'h0003, ra, 16'h0000, '0, '0);
    check_output("oor_read_zero",  {120'b0, d64_rd_data[7:0]},  {120'b0, 8'h00});
    check_output("oor_valid",      {112'b0, d64_rd_valid},       {112'b0, 16'h0003});
    check_output("oor_addr36_kept", {120'b0, d64_rd_data[15:8]}, {120'b0, 8'h14});

    // Asynchronous reset in the middle of a full-width read
    apply_stimulus(16'hFFFF, all_lanes(8'd1), 16'h0000, '0, '0);
    check_output("pre_reset_nonzero", {127'b0, (d256_rd_data != 128'h0)}, {127'b0, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    check_output("async_data_d256",  d256_rd_data,           128'h0);
    check_output("async_valid_d256", {112'b0, d256_rd_valid}, 128'h0);
    check_output("async_data_d64",   d64_rd_data,            128'h0);
    check_output("async_valid_d64",  {112'b0, d64_rd_valid},  128'h0);
    // Traffic presented while reset is held must be ignored
    apply_stimulus(16'hFFFF, all_lanes(8'd2), 16'hFFFF, all_lanes(8'd2), all_lanes(8'hFF));
    reset = 1'b1;
    apply_stimulus(16'hFFFF, all_lanes(8'd2), 16'h0000, '0, '0);
    check_output("post_reset_lane0", {120'b0, d256_rd_data[7:0]}, {120'b0, 8'h02});

    // Random all-lane traffic
    for (int c = 0; c < 10000; c++) begin
      en = 16'($urandom);
      ra = {$urandom, $urandom, $urandom, $urandom};
      wa = {$urandom, $urandom, $urandom, $urandom};
      wd = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(en, ra, 16'($urandom), wa, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/mem_arr.md
# mem_arr

Banked on-chip operand memory for the systolic array. It has one independent 8-bit-wide bank per array row/column lane. Each lane is read with its own enable and 8-bit address, which the read controller drives as a staggered diagonal wavefront. Each lane's read word is registered and presented one cycle later. Lanes not enabled output zero, so the array sees correctly skewed data with zero padding. A separate per-lane write port loads operands from the host/DMA side.

## Interface
- `width_height`, default 16: number of lanes and banks.
- `depth`, default 256: words per bank. Fixed by the 8-bit lane address; legal values are 1..256.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd_en` in `width_height`: per-lane read enable. Bit i belongs to lane i.
- `rd_addr` in `8*width_height`: per-lane read address. Lane i is `rd_addr[8i+7:8i]`.
- `wr_en` in `width_height`: per-lane write enable.
- `wr_addr` in `8*width_height`: per-lane write address, using the same lane packing as `rd_addr`.
- `wr_data` in `8*width_height`: per-lane write data. Lane i is `wr_data[8i+7:8i]`.
- `rd_data` out `8*width_height`: registered per-lane read data, using the same packing.
- `rd_valid` out `width_height`: registered copy of `rd_en`. Bit i marks `rd_data` lane i as a real memory word.

## Operation
- **Banks.** Each lane i owns bank i, organised as `depth` x 8 bits. There are no cross-lane accesses.
- **Read.** When `rd_en[i]` is 1 at edge k, `rd_data` lane i takes the contents of `bank_i[rd_addr lane i]` as they stand before edge k. `rd_valid[i]` is 1 after edge k.
- **Idle lane.** When `rd_en[i]` is 0 at edge k, `rd_data` lane i is 8'h00 and `rd_valid[i]` is 0 after edge k. This zero fill is required; lanes do not hold their last value.
- **Write.** When `wr_en[i]` is 1 at edge k, `bank_i[wr_addr lane i]` takes `wr_data` lane i.
- **Read/write collision.** A read and a write in the same lane at the same address on the same edge returns the old data (read-before-write). The new data is visible to a read on edge k+1 or later.
- **Different-address read/write** in the same lane on the same edge: both take effect with no interaction.
- **Out-of-range addresses** (address >= `depth`):
  - a write is dropped, and bank contents are unchanged;
  - a read returns 8'h00, but `rd_valid[i]` still follows `rd_en[i]`.
- **Reset asserted** (`reset` = 0): `rd_data` goes to all zeros and `rd_valid` to all zeros immediately, without waiting for a clock edge.
- **Reset and bank contents.** Bank contents are not reset. They are undefined after power-up and are preserved across reset.
- **During reset:** writes and reads are ignored.
- **Reset mid-operation:** any read in flight is discarded, and no partial write occurs.
- **Reset release:** the first edge with `reset` = 1 operates normally.

## Timing
- Read latency: 1 cycle from the `rd_en`/`rd_addr` sample edge to `rd_data`/`rd_valid`. Output comes directly from flops, with no combinational path from inputs to outputs.
- Write latency: data is readable on the edge after the write edge.
- Throughput: one read and one write per lane per cycle, on all lanes simultaneously.
- The read controller's registered `rd_en`/`rd_addr` connect directly to this block. The diagonal wavefront is reproduced on `rd_valid`/`rd_data` delayed by exactly one cycle.
- No handshake or backpressure. The consumer must accept every cycle.

## Test plan
- **Basic write then read.** Reset; write lane 0 addr 5 = 8'hA5 and lane 15 addr 255 = 8'h3C; on the next cycle read both. Required one cycle later: lane 0 = A5, lane 15 = 3C, `rd_valid` = 16'h8001, all other lanes 00.
- **Wavefront.** Preload bank i addr j = {i[3:0], j[3:0]}. Drive `rd_en` = 0001, 0003, 0007, … with addresses advancing as the read controller does. Required: `rd_valid` repeats the pattern one cycle late, and each enabled lane returns {i,j} while disabled lanes are 00.
- **Collision.** Bank 3 addr 7 = 8'h11. On one edge, write 8'h22 and read addr 7 in lane 3. Required: `rd_data` lane 3 = 11. A read on the next edge returns 22.
- **Out-of-range** (`depth` = 64). Write addr 100 = 8'hFF, then read addr 100 and addr 36. Required: the read at 100 returns 00 with `rd_valid` = 1, and addr 36 still holds its prior value.
- **Asynchronous reset mid-read.** With `rd_en` = FFFF and `rd_data` nonzero, pull `reset` low between edges. Required: `rd_data`/`rd_valid` go to 0 before the next edge. After release, previously written words read back unchanged.
- **Simultaneous all-lane traffic.** On every cycle, write random data to all 16 lanes and read different addresses. Required: outputs match a scoreboard model cycle-for-cycle over 10k cycles.
